stopwatch_core: RTL and testbench

Stopwatch timekeeping stage that sits directly downstream of the 50 MHz-to-100 Hz clock divider. It runs entirely on `CLK_50MHz` and treats the divider's `CLK_100Hz` output as a data input: it synchronises the signal, edge-detects it, and accumulates centiseconds, seconds and minutes in BCD. Control comes from debounced single-cycle button pulses: start/stop, lap and clear. It drives a 6-digit BCD time value to the display multiplexer, with a lap-freeze capability.

---
 rtl/stopwatch_core.sv | 140 ++++++++++++++
 tb/tb_stopwatch_core.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_core.sv
// Stopwatch timekeeping: synchronises the 100 Hz divider output, edge-detects it and
// accumulates mm:ss.cc in BCD under start/stop, lap and clear pulse control.
module stopwatch_core #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        CLK_50MHz,
  input  logic        reset_n,
  input  logic        CLK_100Hz,
  input  logic        start_stop,
  input  logic        lap,
  input  logic        clear,
  output logic [23:0] time_bcd,
  output logic        running,
  output logic        lap_active,
  output logic        rollover,
  output logic [1:0]  state_dbg
);

  // Control inputs are single-cycle pulses; there is no back-pressure, a pulse is
  // consumed in the cycle it is high. Priority: start_stop > lap > clear.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_STOP = 2'd2,
    S_LAP  = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   dly_q;
  logic                   tick;
  logic [23:0]            count_q, count_d;
  logic [23:0]            lap_q;
  logic                   rollover_q;
  logic                   lap_load;
  logic                   count_clr;
  logic                   count_en;
  logic                   carry;
  logic [3:0]             dig;
  logic [3:0]             dmax;

  always_ff @(posedge CLK_50MHz or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
      dly_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], CLK_100Hz};
      dly_q  <= sync_q[SYNC_STAGES-1];
    end
  end

  assign tick = sync_q[SYNC_STAGES-1] & ~dly_q;

  always_ff @(posedge CLK_50MHz or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    lap_load  = 1'b0;
    count_clr = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_stop) state_d = S_RUN;
      end
      S_RUN: begin
        if (start_stop) begin
          state_d = S_STOP;
        end else if (lap) begin
          state_d  = S_LAP;
          lap_load = 1'b1;
        end
      end
      S_LAP: begin
        if (start_stop)  state_d = S_STOP;
        else if (lap)    state_d = S_RUN;
      end
      S_STOP: begin
        if (start_stop) begin
          state_d = S_RUN;
        end else if (clear) begin
          state_d   = S_IDLE;
          count_clr = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Counting is gated by the registered state, so a tick alongside a start is lost
  // and a tick alongside a stop still lands.
  assign count_en = tick & ((state_q == S_RUN) | (state_q == S_LAP));

  // Ripple-carry BCD increment; the top-digit carry-out is the wrap.
  always_comb begin
    count_d = count_q;
    carry   = count_en;
    dig     = 4'd0;
    dmax    = 4'd9;
    for (int i = 0; i < 6; i++) begin
      dig  = count_q[i*4 +: 4];
      dmax = ((i == 3) || (i == 5)) ? 4'd5 : 4'd9;
      if (carry) begin
        if (dig >= dmax) begin
          count_d[i*4 +: 4] = 4'd0;
        end else begin
          count_d[i*4 +: 4] = dig + 4'd1;
          carry = 1'b0;
        end
      end
    end
    if (count_clr) begin
      count_d = '0;
      carry   = 1'b0;
    end
  end

  always_ff @(posedge CLK_50MHz or negedge reset_n) begin
    if (!reset_n) begin
      count_q    <= '0;
      lap_q      <= '0;
      rollover_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      rollover_q <= carry;
      if (lap_load) lap_q <= count_q;
    end
  end

  assign time_bcd   = (state_q == S_LAP) ? lap_q : count_q;
  assign running    = (state_q == S_RUN) | (state_q == S_LAP);
  assign lap_active = (state_q == S_LAP);
  assign rollover   = rollover_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_stopwatch_core.sv
// Bench for stopwatch_core: integer-centisecond reference model checked every cycle,
// directed scenarios with literal expectations, then a randomized control phase.
`timescale 1ns/1ps
module tb_stopwatch_core;

  localparam int SYNC = 2;
  localparam int M_IDLE = 0, M_RUN = 1, M_STOP = 2, M_LAP = 3;

  logic        CLK_50MHz;
  logic        reset_n;
  logic        CLK_100Hz;
  logic        start_stop, lap, clear;
  logic [23:0] time_bcd;
  logic        running, lap_active, rollover;
  logic [1:0]  state_dbg;

  int n_cmp = 0;
  int n_err = 0;

  // reference model: centiseconds as a plain integer
  int m_st, nst, m_cnt, m_lap;
  bit m_roll, tk, en, zero_cnt;
  bit hist[$];

  stopwatch_core #(.SYNC_STAGES(SYNC)) dut (
    .CLK_50MHz (CLK_50MHz),
    .reset_n   (reset_n),
    .CLK_100Hz (CLK_100Hz),
    .start_stop(start_stop),
    .lap       (lap),
    .clear     (clear),
    .time_bcd  (time_bcd),
    .running   (running),
    .lap_active(lap_active),
    .rollover  (rollover),
    .state_dbg (state_dbg)
  );

  // clock / reset
  initial begin
    CLK_50MHz = 1'b0;
    forever #10 CLK_50MHz = ~CLK_50MHz;
  end

  function automatic logic [23:0] to_bcd(input int v);
    int m, s, c;
    m = v / 6000;
    s = (v / 100) % 60;
    c = v % 100;
    return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10), 4'(c / 10), 4'(c % 10)};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // model step and per-cycle compare
  always @(posedge CLK_50MHz) begin
    if (!reset_n) begin
      m_st = M_IDLE; m_cnt = 0; m_lap = 0; m_roll = 1'b0;
      hist.delete();
      for (int i = 0; i <= SYNC; i++) hist.push_back(1'b0);
    end else begin
      tk = hist[SYNC-1] && !hist[SYNC];
      en = tk && (m_st == M_RUN || m_st == M_LAP);
      m_roll = 1'b0; zero_cnt = 1'b0; nst = m_st;
      case (m_st)
        M_IDLE: if (start_stop) nst = M_RUN;
        M_RUN: begin
          if (start_stop) nst = M_STOP;
          else if (lap) begin nst = M_LAP; m_lap = m_cnt; end
        end
        M_LAP: begin
          if (start_stop) nst = M_STOP;
          else if (lap) nst = M_RUN;
        end
        default: begin
          if (start_stop) nst = M_RUN;
          else if (clear) begin nst = M_IDLE; zero_cnt = 1'b1; end
        end
      endcase
      if (en) begin
        m_cnt = (m_cnt + 1) % 360000;
        m_roll = (m_cnt == 0);
      end
      if (zero_cnt) m_cnt = 0;
      m_st = nst;
      hist.push_front(CLK_100Hz);
      void'(hist.pop_back());
    end
    #1;
    chk("time_bcd", {8'h0, time_bcd}, {8'h0, (m_st == M_LAP) ? to_bcd(m_lap) : to_bcd(m_cnt)});
    chk("running", {31'h0, running}, {31'h0, (m_st == M_RUN || m_st == M_LAP)});
    chk("lap_active", {31'h0, lap_active}, {31'h0, (m_st == M_LAP)});
    chk("rollover", {31'h0, rollover}, {31'h0, m_roll});
  end

  // driver tasks
  task automatic pulse(input logic s, input logic l, input logic c);
    @(negedge CLK_50MHz);
    start_stop = s; lap = l; clear = c;
    @(negedge CLK_50MHz);
    start_stop = 1'b0; lap = 1'b0; clear = 1'b0;
  endtask

  task automatic ticks(input int n, input int half);
    for (int k = 0; k < n; k++) begin
      @(negedge CLK_50MHz);
      CLK_100Hz = 1'b1;
      repeat (half - 1) @(negedge CLK_50MHz);
      CLK_100Hz = 1'b0;
      repeat (half) @(negedge CLK_50MHz);
    end
    repeat (2) @(negedge CLK_50MHz);
  endtask

  task automatic do_reset();
    @(negedge CLK_50MHz);
    reset_n = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (k % 3 == 0) CLK_100Hz = ~CLK_100Hz;
      @(negedge CLK_50MHz);
    end
    CLK_100Hz = 1'b0;
    reset_n = 1'b1;
  endtask

  int   ph;
  int   r;
  bit   seen;
  logic [23:0] t_at;

  initial begin
    reset_n = 1'b0; CLK_100Hz = 1'b0;
    start_stop = 1'b0; lap = 1'b0; clear = 1'b0;

    // reset with the 100 Hz input toggling, then ticks in IDLE do nothing
    do_reset();
    chk("rst_time", {8'h0, time_bcd}, 32'h0);
    chk("rst_running", {31'h0, running}, 32'h0);
    ticks(10, 3);
    chk("idle_no_count", {8'h0, time_bcd}, 32'h0);

    // start, then first increment exactly three edges after the sampled rise
    pulse(1'b1, 1'b0, 1'b0);
    chk("start_running", {31'h0, running}, 32'h1);
    CLK_100Hz = 1'b1;
    @(posedge CLK_50MHz); #2;
    chk("lat_edge_n", {8'h0, time_bcd}, 32'h0);
    @(posedge CLK_50MHz); #2;
    chk("lat_edge_n1", {8'h0, time_bcd}, 32'h0);
    @(posedge CLK_50MHz); #2;
    chk("lat_edge_n2", {8'h0, time_bcd}, 32'h000001);
    @(negedge CLK_50MHz);
    repeat (16) @(negedge CLK_50MHz);
    CLK_100Hz = 1'b0;
    repeat (20) @(negedge CLK_50MHz);
    ticks(99, 20);
    chk("basic_100", {8'h0, time_bcd}, 32'h000100);
    chk("basic_running", {31'h0, running}, 32'h1);

    // lap freeze
    pulse(1'b1, 1'b0, 1'b0);
    pulse(1'b0, 1'b0, 1'b1);
    chk("clear_zero", {8'h0, time_bcd}, 32'h0);
    pulse(1'b1, 1'b0, 1'b0);
    ticks(25, 3);
    chk("pre_lap", {8'h0, time_bcd}, 32'h000025);
    pulse(1'b0, 1'b1, 1'b0);
    chk("lap_active", {31'h0, lap_active}, 32'h1);
    ticks(50, 3);
    chk("lap_frozen", {8'h0, time_bcd}, 32'h000025);
    pulse(1'b0, 1'b1, 1'b0);
    chk("lap_live", {8'h0, time_bcd}, 32'h000075);
    chk("lap_off", {31'h0, lap_active}, 32'h0);

    // stop / clear / priority
    pulse(1'b1, 1'b0, 1'b0);
    pulse(1'b0, 1'b0, 1'b1);
    pulse(1'b1, 1'b0, 1'b0);
    ticks(10, 3);
    pulse(1'b1, 1'b0, 1'b0);
    chk("stop_10", {8'h0, time_bcd}, 32'h000010);
    chk("stop_running", {31'h0, running}, 32'h0);
    ticks(20, 3);
    chk("stop_hold", {8'h0, time_bcd}, 32'h000010);
    pulse(1'b0, 1'b0, 1'b1);
    chk("stop_clear", {8'h0, time_bcd}, 32'h0);
    ticks(3, 3);
    chk("cleared_idle", {8'h0, time_bcd}, 32'h0);
    pulse(1'b1, 1'b0, 1'b0);
    ticks(5, 3);
    pulse(1'b1, 1'b0, 1'b0);
    pulse(1'b1, 1'b0, 1'b1);
    chk("ss_over_clear_run", {31'h0, running}, 32'h1);
    chk("ss_over_clear_cnt", {8'h0, time_bcd}, 32'h000005);
    pulse(1'b1, 1'b0, 1'b0);
    // rise sampled two edges before the start pulse: its tick meets STOP->RUN
    CLK_100Hz = 1'b1;
    @(negedge CLK_50MHz);
    @(negedge CLK_50MHz);
    start_stop = 1'b1;
    @(negedge CLK_50MHz);
    start_stop = 1'b0;
    chk("aligned_start", {8'h0, time_bcd}, 32'h000005);
    chk("aligned_running", {31'h0, running}, 32'h1);
    @(negedge CLK_50MHz);
    CLK_100Hz = 1'b0;
    repeat (4) @(negedge CLK_50MHz);
    ticks(1, 3);
    chk("after_aligned", {8'h0, time_bcd}, 32'h000006);

    // wrap from 59:59.99
    force dut.count_q = 24'h595999;
    m_cnt = 359999;
    @(negedge CLK_50MHz);
    release dut.count_q;
    chk("preset_wrap", {8'h0, time_bcd}, 32'h595999);
    CLK_100Hz = 1'b1;
    seen = 1'b0; t_at = 24'hFFFFFF;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge CLK_50MHz);
      if (rollover) begin seen = 1'b1; t_at = time_bcd; end
    end
    chk("wrap_seen", {31'h0, seen}, 32'h1);
    chk("wrap_time", {8'h0, t_at}, 32'h0);
    @(negedge CLK_50MHz);
    chk("wrap_one_cycle", {31'h0, rollover}, 32'h0);
    chk("wrap_running", {31'h0, running}, 32'h1);
    CLK_100Hz = 1'b0;
    repeat (4) @(negedge CLK_50MHz);

    // randomized control with a randomized 100 Hz waveform
    ph = 3;
    for (int k = 0; k < 4000; k++) begin
      @(negedge CLK_50MHz);
      ph--;
      if (ph <= 0) begin
        CLK_100Hz = ~CLK_100Hz;
        ph = $urandom_range(3, 8);
      end
      r = $urandom_range(0, 39);
      start_stop = (r == 0);
      lap        = (r == 1);
      clear      = (r == 2);
    end
    @(negedge CLK_50MHz);
    start_stop = 1'b0; lap = 1'b0; clear = 1'b0;

    // mid-run asynchronous reset while in LAP at 00:02.37
    do_reset();
    pulse(1'b1, 1'b0, 1'b0);
    ticks(237, 3);
    pulse(1'b0, 1'b1, 1'b0);
    chk("lap_237", {8'h0, time_bcd}, 32'h000237);
    @(posedge CLK_50MHz);
    #5 reset_n = 1'b0;
    #1;
    chk("async_time", {8'h0, time_bcd}, 32'h0);
    chk("async_lap", {31'h0, lap_active}, 32'h0);
    chk("async_running", {31'h0, running}, 32'h0);
    chk("async_roll", {31'h0, rollover}, 32'h0);
    for (int k = 0; k < 10; k++) begin
      @(negedge CLK_50MHz);
      if (k % 3 == 0) CLK_100Hz = ~CLK_100Hz;
    end
    CLK_100Hz = 1'b0;
    @(negedge CLK_50MHz);
    reset_n = 1'b1;
    ticks(5, 3);
    chk("post_rst_idle", {8'h0, time_bcd}, 32'h0);
    pulse(1'b1, 1'b0, 1'b0);
    ticks(3, 3);
    chk("post_rst_run", {8'h0, time_bcd}, 32'h000003);

    repeat (3) @(negedge CLK_50MHz);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
